// File: rtl/ahbl_apb_pkg.sv
// ahbl_apb_pkg: shared constants for the AHB-Lite to APB bridge.
//   - apb_state_e : bridge FSM states (2-bit encoding)
//   - HTRANS_*    : AHB transfer type codes
//   - HRESP_*     : AHB response codes
package ahbl_apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StErr    = 2'd3
  } apb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_to_apb.sv
// ahbl_to_apb: AHB-Lite slave to single APB master bridge.
// One APB transfer per AHB transfer; AHB wait states are held until APB completes, and
// pslverr becomes a two-cycle AHB ERROR response.
//
// Optional build macro AHBL_TO_APB_TIMEOUT_EN: an ACCESS-phase watchdog that turns an APB
// transfer stalled for TIMEOUT_CYCLES cycles into an AHB ERROR. Undefined by default.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ahbls_hready        : bus-wide hready (input)
//   ahbls_hready_resp   : this slave's hready
//   ahbls_hresp         : 0 OKAY, 1 ERROR
//   ahbls_haddr/hwrite/htrans/hsize : address phase (hsize ignored)
//   ahbls_hwdata/hrdata : data phase
//   apbm_*              : APB master port
module ahbl_to_apb
  import ahbl_apb_pkg::*;
#(
  parameter int unsigned W_HADDR        = 32,
  parameter int unsigned W_PADDR        = 16,
  parameter int unsigned W_DATA         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic               apbm_pready,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pslverr
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e           state_q, state_d;
  logic [W_PADDR-1:0]   paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;

  logic accept;
  logic timeout;
  logic pready_eff;
  logic pslverr_eff;

  // hsize, upper address bits and htrans[0] carry no information for this bridge.
  logic unused_ok;
  assign unused_ok = ^{ahbls_hsize, ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0]};

  assign accept = ahbls_hready && ahbls_htrans[1];

`ifdef AHBL_TO_APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts stalled ACCESS cycles already seen; fires on the TIMEOUT_CYCLES-th stalled one.
  assign timeout = (state_q == StAccess) && !apbm_pready &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StAccess && !apbm_pready) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // A timeout masquerades as an APB error completion.
  assign pready_eff  = apbm_pready || timeout;
  assign pslverr_eff = apbm_pslverr || timeout;

  always_comb begin
    state_d           = state_q;
    paddr_d           = paddr_q;
    pwrite_d          = pwrite_q;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = HRESP_OKAY;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSetup;
      end
      StSetup: begin
        ahbls_hready_resp = 1'b0;
        state_d           = StAccess;
      end
      StAccess: begin
        if (!pready_eff) begin
          ahbls_hready_resp = 1'b0;
        end else if (pslverr_eff) begin
          ahbls_hready_resp = 1'b0;
          ahbls_hresp       = HRESP_ERROR;
          state_d           = StErr;
        end else begin
          state_d = accept ? StSetup : StIdle;
        end
      end
      StErr: begin
        ahbls_hresp = HRESP_ERROR;
        state_d     = accept ? StSetup : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Address is captured only when a new data phase actually starts.
    if (state_d == StSetup) begin
      paddr_d  = ahbls_haddr[W_PADDR-1:0];
      pwrite_d = ahbls_hwrite;
    end
    psel_d    = (state_d == StSetup) || (state_d == StAccess);
    penable_d = (state_d == StAccess);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign apbm_paddr   = paddr_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_psel    = psel_q;
  assign apbm_penable = penable_q;
  assign apbm_pwdata  = ahbls_hwdata;
  assign ahbls_hrdata = apbm_prdata;

endmodule
